key_cmd_decoder: RTL and testbench
==================================

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 Parameter REPEAT_DELAY, default 50_000_000, cycles a movement key is held before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000, cycles between auto-repeat steps.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_event  input  11  keyboard event: [10] event valid, [9] extended (E0) prefix, [8] break (release), [7:0] scan code.
REQ-006 cursor_x  output  3  board column, 0..7.
REQ-007 cursor_y  output  3  board row, 0..7; 0 is the top row.
REQ-008 sel_pulse  output  1  one-cycle select/confirm strobe (Space).
REQ-009 promo_pulse  output  1  one-cycle promotion-cycle strobe (G).
REQ-010 held  output  1  high while an accepted key is held down.

Function
REQ-011 Events are sampled only in cycles where key_event[10]=1; other cycles are ignored.
REQ-012 Make codes move the cursor: W/up dy=-1; S/X/down dy=+1; A/left dx=-1; D/right dx=+1; Q (-1,-1); E (+1,-1); Z (-1,+1); C (+1,+1).
REQ-013 Arrow keys are accepted only with [9]=1 (codes 75 up, 72 down, 6B left, 74 right); letter codes are accepted only with [9]=0.
REQ-014 Cursor arithmetic is 3-bit modulo-8: 7+1 wraps to 0, and 0-1 wraps to 7, independently on each axis.
REQ-015 Cursor registers update exactly one cycle after the accepting event.
REQ-016 Space (29) asserts sel_pulse, and G (34) asserts promo_pulse, for exactly one cycle, one cycle after the accepting event.
REQ-017 FSM states: IDLE, HELD, REPEAT; REPEAT exists only under the configuration macro.
REQ-018 IDLE: a recognised make is accepted, its code and extended bit are latched, and the FSM goes to HELD.
REQ-019 IDLE: unrecognised makes and all breaks are ignored.
REQ-020 HELD: a make equal to the latched code (typematic repeat from the keyboard) is ignored.
REQ-021 HELD: a recognised make with a different code is accepted immediately and replaces the latched code; the FSM stays in HELD.
REQ-022 HELD/REPEAT: a break matching the latched code and extended bit returns the FSM to IDLE; a non-matching break is ignored.
REQ-023 held=1 exactly in HELD and REPEAT.
REQ-024 At most one cursor step and one pulse occur per cycle.
REQ-025 If an event and a repeat tick coincide, the event wins and the tick is discarded.

Reset
REQ-026 Reset takes effect on the clock edge while rst=1: cursor_x=0, cursor_y=0, sel_pulse=0, promo_pulse=0, held=0, FSM=IDLE, latched code=00, repeat counter=0.
REQ-027 Reset asserted mid-hold or mid-repeat discards the held key, so a later break for that key is ignored.

Configuration
REQ-028 Macro KEY_CMD_REPEAT_EN, when defined: in HELD with a movement key latched, a counter runs.
REQ-029 Under KEY_CMD_REPEAT_EN: after REPEAT_DELAY cycles the FSM enters REPEAT and steps the cursor once.
REQ-030 Under KEY_CMD_REPEAT_EN: in REPEAT, the cursor steps once every REPEAT_PERIOD cycles until the matching break.
REQ-031 Under KEY_CMD_REPEAT_EN: Space and G never auto-repeat.
REQ-032 Under KEY_CMD_REPEAT_EN: accepting a new code resets the counter and returns the FSM to HELD.
REQ-033 Without KEY_CMD_REPEAT_EN: no counter or REPEAT state exists, and a held key produces exactly one step.

Structure
REQ-034 Shared package chess_kbd_pkg holds the scan-code constants (letters, Space, G, arrow codes), the FSM state enum, and the key_event field bit positions.
REQ-035 One sub-module, key_repeat_timer (counter plus tick generator), is instantiated only under KEY_CMD_REPEAT_EN; the direction decode stays inline.

Verification
REQ-036 Reset, then make D ({1,0,0,23}) -> cursor=(1,0) next cycle, held=1.
REQ-037 Cursor at (0,0), then make Q -> cursor=(7,7); then break Q, make C -> cursor=(0,0).
REQ-038 Make W followed by five repeated make W before break -> cursor_y decrements exactly once; break W -> held=0.
REQ-039 Make Space -> sel_pulse high for exactly 1 cycle; make 34 with [9]=1 -> no promo_pulse; make E0 74 -> cursor_x+1.
REQ-040 Hold D with REPEAT_DELAY=20 and REPEAT_PERIOD=5, macro on -> steps at +1, +21, +26, +31 cycles, stopping at the break; macro off -> a single step.
REQ-041 Hold A, pulse rst, then break A -> cursor=(0,0), held=0, no step.

Source files
------------

// File: rtl/key_cmd_decoder_pkg.sv
// chess_kbd_pkg: shared definitions for the chess keyboard command decoder.
//   - key_event field positions (valid / E0 prefix / break / scan code)
//   - PS/2 set-2 scan codes for the letter keys, Space, G and the arrow keys
//   - key kind and FSM state enums
// The REPEAT state is only present when KEY_CMD_REPEAT_EN is defined.
package chess_kbd_pkg;

  localparam int EV_W        = 11;
  localparam int EV_VALID    = 10;
  localparam int EV_EXT      = 9;
  localparam int EV_BRK      = 8;
  localparam int EV_CODE_MSB = 7;

  // Letter codes, only meaningful without the E0 prefix
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_G     = 8'h34;

  // Arrow codes, only meaningful with the E0 prefix
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    K_MOVE  = 2'd0,
    K_SEL   = 2'd1,
    K_PROMO = 2'd2
  } key_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1
`ifdef KEY_CMD_REPEAT_EN
    , ST_REPEAT = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/key_cmd_decoder_if.sv
// key_cmd_decoder_if: keyboard event in, cursor/strobe state out.
//   key_event[10:0] : {valid, E0 prefix, break, scan code}
//   cursor_x/y[2:0] : board position, y=0 is the top row
//   sel_pulse       : one-cycle Space strobe
//   promo_pulse     : one-cycle G strobe
//   held            : an accepted key is held down
// master = event source / observer, slave = decoder.
interface key_cmd_decoder_if;
  logic [chess_kbd_pkg::EV_W-1:0] key_event;
  logic [2:0]                     cursor_x;
  logic [2:0]                     cursor_y;
  logic                           sel_pulse;
  logic                           promo_pulse;
  logic                           held;

  modport master (
    output key_event,
    input  cursor_x, cursor_y, sel_pulse, promo_pulse, held
  );

  modport slave (
    input  key_event,
    output cursor_x, cursor_y, sel_pulse, promo_pulse, held
  );
endinterface

// File: rtl/key_cmd_decoder_timer.sv
// key_repeat_timer: auto-repeat counter and tick generator.
// Used only when KEY_CMD_REPEAT_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count (new key accepted or key released)
//   run       : a movement key is held; count only while high
//   rep_mode  : 0 = waiting DELAY cycles, 1 = stepping every PERIOD cycles
//   tick      : one-cycle step request
module key_repeat_timer #(
  parameter int DELAY  = 50_000_000,
  parameter int PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic rep_mode,
  output logic tick
);

  localparam int MAXC = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  // cnt counts edges since the last accept/tick; terminal value is limit
  assign limit = rep_mode ? CW'(PERIOD - 1) : CW'(DELAY - 1);
  // clr masks the tick so a coinciding key event wins
  assign tick  = run && !clr && (cnt == limit);

  always_ff @(posedge clk) begin
    if (rst || clr || !run || tick) cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: turns PS/2 make/break events into chess-board cursor
// moves and select/promotion strobes.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : key_cmd_decoder_if.slave (key_event in; cursor_x, cursor_y,
//          sel_pulse, promo_pulse, held out)
// Optional feature macro KEY_CMD_REPEAT_EN: a held movement key auto-repeats
// after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles. Without it a
// held key gives a single step.
module key_cmd_decoder
  import chess_kbd_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input logic              clk,
  input logic              rst,
  key_cmd_decoder_if.slave bus
);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_cmd_decoder: repeat delay and period must be >= 1");
  end

  logic       ev_valid, ev_ext, ev_brk;
  logic [7:0] ev_code;

  assign ev_valid = bus.key_event[EV_VALID];
  assign ev_ext   = bus.key_event[EV_EXT];
  assign ev_brk   = bus.key_event[EV_BRK];
  assign ev_code  = bus.key_event[EV_CODE_MSB:0];

  state_t     state;
  logic [7:0] lat_code;
  logic       lat_ext;
  logic [2:0] cur_x, cur_y;
  logic       sel_q, promo_q, held_q;

  // Direction decode: deltas are 3-bit two's complement (7 = -1) so the
  // cursor add wraps modulo 8 for free.
  logic       dec_ok;
  key_kind_t  dec_kind;
  logic [2:0] dec_dx, dec_dy;

  always_comb begin
    dec_ok   = 1'b0;
    dec_kind = K_MOVE;
    dec_dx   = 3'd0;
    dec_dy   = 3'd0;
    if (!ev_ext) begin
      case (ev_code)
        SC_W:     begin dec_ok = 1'b1; dec_dy = 3'd7; end
        SC_S,
        SC_X:     begin dec_ok = 1'b1; dec_dy = 3'd1; end
        SC_A:     begin dec_ok = 1'b1; dec_dx = 3'd7; end
        SC_D:     begin dec_ok = 1'b1; dec_dx = 3'd1; end
        SC_Q:     begin dec_ok = 1'b1; dec_dx = 3'd7; dec_dy = 3'd7; end
        SC_E:     begin dec_ok = 1'b1; dec_dx = 3'd1; dec_dy = 3'd7; end
        SC_Z:     begin dec_ok = 1'b1; dec_dx = 3'd7; dec_dy = 3'd1; end
        SC_C:     begin dec_ok = 1'b1; dec_dx = 3'd1; dec_dy = 3'd1; end
        SC_SPACE: begin dec_ok = 1'b1; dec_kind = K_SEL;   end
        SC_G:     begin dec_ok = 1'b1; dec_kind = K_PROMO; end
        default:  ;
      endcase
    end else begin
      case (ev_code)
        SC_UP:    begin dec_ok = 1'b1; dec_dy = 3'd7; end
        SC_DOWN:  begin dec_ok = 1'b1; dec_dy = 3'd1; end
        SC_LEFT:  begin dec_ok = 1'b1; dec_dx = 3'd7; end
        SC_RIGHT: begin dec_ok = 1'b1; dec_dx = 3'd1; end
        default:  ;
      endcase
    end
  end

  // same_key covers both the keyboard's own typematic makes (ignored) and
  // the matching break (release).
  logic same_key, accept, release_hit;

  assign same_key    = (state != ST_IDLE) && (ev_code == lat_code) && (ev_ext == lat_ext);
  assign accept      = ev_valid && !ev_brk && dec_ok && !same_key;
  assign release_hit = ev_valid && ev_brk && same_key;

`ifdef KEY_CMD_REPEAT_EN
  logic       lat_move;
  logic [2:0] lat_dx, lat_dy;
  logic       tick;

  key_repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept || release_hit),
    .run      ((state != ST_IDLE) && lat_move),
    .rep_mode (state == ST_REPEAT),
    .tick     (tick)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_code <= 8'h00;
      lat_ext  <= 1'b0;
      cur_x    <= 3'd0;
      cur_y    <= 3'd0;
      sel_q    <= 1'b0;
      promo_q  <= 1'b0;
      held_q   <= 1'b0;
`ifdef KEY_CMD_REPEAT_EN
      lat_move <= 1'b0;
      lat_dx   <= 3'd0;
      lat_dy   <= 3'd0;
`endif
    end else begin
      sel_q   <= 1'b0;
      promo_q <= 1'b0;
      if (accept) begin
        state    <= ST_HELD;
        held_q   <= 1'b1;
        lat_code <= ev_code;
        lat_ext  <= ev_ext;
`ifdef KEY_CMD_REPEAT_EN
        lat_move <= (dec_kind == K_MOVE);
        lat_dx   <= dec_dx;
        lat_dy   <= dec_dy;
`endif
        case (dec_kind)
          K_SEL:   sel_q   <= 1'b1;
          K_PROMO: promo_q <= 1'b1;
          default: begin
            cur_x <= cur_x + dec_dx;
            cur_y <= cur_y + dec_dy;
          end
        endcase
      end else if (release_hit) begin
        state  <= ST_IDLE;
        held_q <= 1'b0;
`ifdef KEY_CMD_REPEAT_EN
      end else if (tick) begin
        cur_x <= cur_x + lat_dx;
        cur_y <= cur_y + lat_dy;
        state <= ST_REPEAT;
`endif
      end
    end
  end

  assign bus.cursor_x    = cur_x;
  assign bus.cursor_y    = cur_y;
  assign bus.sel_pulse   = sel_q;
  assign bus.promo_pulse = promo_q;
  assign bus.held        = held_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Self-checking bench for key_cmd_decoder (short repeat timings: 20 / 5).
module tb_key_cmd_decoder;
  import chess_kbd_pkg::*;

  localparam int DLY = 20;
  localparam int PER = 5;
`ifdef KEY_CMD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  key_cmd_decoder_if bus();

  key_cmd_decoder #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: board position, held key and cycles since it was pressed
  int       mx, my, mdx, mdy, mt;
  bit       msel, mpro, mheld, mext, mmove;
  bit [7:0] mcode;

  function automatic logic [10:0] mk(input bit ext, input bit brk, input logic [7:0] code);
    return {1'b1, ext, brk, code};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.cursor_x, bus.cursor_y, bus.sel_pulse, bus.promo_pulse, bus.held};
  endfunction

  function automatic logic [8:0] mouts();
    logic [2:0] x, y;
    x = mx[2:0];
    y = my[2:0];
    return {x, y, msel, mpro, mheld};
  endfunction

  // kind: 0 move, 1 select, 2 promote
  function automatic void m_decode(input bit ext, input bit [7:0] c, output bit ok,
                                   output int kind, output int dx, output int dy);
    ok = 1; kind = 0; dx = 0; dy = 0;
    if (!ext) begin
      if      (c == 8'h1D) dy = -1;
      else if (c == 8'h1B || c == 8'h22) dy = 1;
      else if (c == 8'h1C) dx = -1;
      else if (c == 8'h23) dx = 1;
      else if (c == 8'h15) begin dx = -1; dy = -1; end
      else if (c == 8'h24) begin dx = 1;  dy = -1; end
      else if (c == 8'h1A) begin dx = -1; dy = 1;  end
      else if (c == 8'h21) begin dx = 1;  dy = 1;  end
      else if (c == 8'h29) kind = 1;
      else if (c == 8'h34) kind = 2;
      else ok = 0;
    end else begin
      if      (c == 8'h75) dy = -1;
      else if (c == 8'h72) dy = 1;
      else if (c == 8'h6B) dx = -1;
      else if (c == 8'h74) dx = 1;
      else ok = 0;
    end
  endfunction

  function automatic void model_edge(input logic [10:0] ev, input logic r);
    bit ok, same;
    int kind, dx, dy;
    bit v = ev[10];
    bit e = ev[9];
    bit b = ev[8];
    bit [7:0] c = ev[7:0];
    if (r) begin
      mx = 0; my = 0; msel = 0; mpro = 0; mheld = 0;
      mcode = 0; mext = 0; mmove = 0; mdx = 0; mdy = 0; mt = 0;
      return;
    end
    msel = 0;
    mpro = 0;
    m_decode(e, c, ok, kind, dx, dy);
    same = mheld && (c == mcode) && (e == mext);
    if (v && !b && ok && !same) begin
      mheld = 1; mcode = c; mext = e; mt = 0;
      mmove = (kind == 0); mdx = dx; mdy = dy;
      if (kind == 1) msel = 1;
      else if (kind == 2) mpro = 1;
      else begin mx = (mx + dx + 8) % 8; my = (my + dy + 8) % 8; end
    end else if (v && b && same) begin
      mheld = 0;
    end else if (mheld) begin
      mt++;
      if (REP_EN && mmove && mt >= DLY && (mt - DLY) % PER == 0) begin
        mx = (mx + mdx + 8) % 8;
        my = (my + mdy + 8) % 8;
      end
    end
  endfunction

  task automatic drive(input logic [10:0] ev, input logic r);
    bus.key_event = ev;
    rst = r;
    @(posedge clk);
    model_edge(ev, r);
    #1;
    bus.key_event = '0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive('0, 1'b1);
    drive('0, 1'b1);
    n_cmp++;
    if (outs() !== 9'b0) begin
      n_bad++; $display("FAIL reset_init: got %b want %b", outs(), 9'b0);
    end
    drive(mk(0, 0, SC_D), 1'b0);
    drive(mk(0, 0, SC_C), 1'b1);   // reset beats a simultaneous event
    n_cmp++;
    if (outs() !== 9'b0) begin
      n_bad++; $display("FAIL reset_over_event: got %b want %b", outs(), 9'b0);
    end
  endtask

  task automatic test_make_d();
    drive('0, 1'b1);
    drive(mk(0, 0, SC_D), 1'b0);
    n_cmp++;
    if (outs() !== {3'd1, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL make_d: got %b want %b", outs(), {3'd1, 3'd0, 3'b001});
    end
    drive(mk(0, 1, SC_D), 1'b0);
    n_cmp++;
    if (outs() !== {3'd1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL break_d: got %b want %b", outs(), {3'd1, 3'd0, 3'b000});
    end
  endtask

  task automatic test_wrap();
    drive('0, 1'b1);
    drive(mk(0, 0, SC_Q), 1'b0);
    n_cmp++;
    if (outs() !== {3'd7, 3'd7, 3'b001}) begin
      n_bad++; $display("FAIL wrap_q: got %b want %b", outs(), {3'd7, 3'd7, 3'b001});
    end
    drive(mk(0, 1, SC_Q), 1'b0);
    drive(mk(0, 0, SC_C), 1'b0);
    n_cmp++;
    if (outs() !== {3'd0, 3'd0, 3'b001}) begin
      n_bad++; $display("FAIL wrap_c: got %b want %b", outs(), {3'd0, 3'd0, 3'b001});
    end
    drive(mk(0, 1, SC_C), 1'b0);
  endtask

  task automatic test_typematic();
    drive('0, 1'b1);
    drive(mk(0, 0, SC_W), 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, SC_W), 1'b0);
      n_cmp++;
      if (outs() !== {3'd0, 3'd7, 3'b001}) begin
        n_bad++; $display("FAIL typematic_%0d: got %b want %b", i, outs(), {3'd0, 3'd7, 3'b001});
      end
    end
    drive(mk(0, 1, SC_W), 1'b0);
    n_cmp++;
    if (outs() !== {3'd0, 3'd7, 3'b000}) begin
      n_bad++; $display("FAIL typematic_break: got %b want %b", outs(), {3'd0, 3'd7, 3'b000});
    end
  endtask

  task automatic test_pulses();
    drive('0, 1'b1);
    drive(mk(0, 0, SC_SPACE), 1'b0);
    n_cmp++;
    if (outs() !== {6'd0, 3'b101}) begin
      n_bad++; $display("FAIL sel_on: got %b want %b", outs(), {6'd0, 3'b101});
    end
    drive('0, 1'b0);
    n_cmp++;
    if (outs() !== {6'd0, 3'b001}) begin
      n_bad++; $display("FAIL sel_off: got %b want %b", outs(), {6'd0, 3'b001});
    end
    drive(mk(0, 1, SC_SPACE), 1'b0);
    drive(mk(1, 0, SC_G), 1'b0);     // G with E0 prefix is not a command
    n_cmp++;
    if (outs() !== 9'b0) begin
      n_bad++; $display("FAIL ext_g_ignored: got %b want %b", outs(), 9'b0);
    end
    drive(mk(1, 0, SC_D), 1'b0);     // letter with prefix ignored
    drive(mk(0, 0, SC_RIGHT), 1'b0); // arrow without prefix ignored
    n_cmp++;
    if (outs() !== 9'b0) begin
      n_bad++; $display("FAIL prefix_ignored: got %b want %b", outs(), 9'b0);
    end
    drive(mk(1, 0, SC_RIGHT), 1'b0);
    n_cmp++;
    if (outs() !== {3'd1, 3'd0, 3'b001}) begin
      n_bad++; $display("FAIL arrow_right: got %b want %b", outs(), {3'd1, 3'd0, 3'b001});
    end
    drive(mk(1, 1, SC_RIGHT), 1'b0);
    drive(mk(0, 0, SC_G), 1'b0);
    n_cmp++;
    if (outs() !== {3'd1, 3'd0, 3'b011}) begin
      n_bad++; $display("FAIL promo_on: got %b want %b", outs(), {3'd1, 3'd0, 3'b011});
    end
    drive('0, 1'b0);
    n_cmp++;
    if (outs() !== {3'd1, 3'd0, 3'b001}) begin
      n_bad++; $display("FAIL promo_off: got %b want %b", outs(), {3'd1, 3'd0, 3'b001});
    end
    drive(mk(0, 1, SC_G), 1'b0);
  endtask

  task automatic test_repeat();
    int seen[$];
    int want[$];
    logic [2:0] px;
    if (REP_EN) want = '{0, 20, 25, 30};
    else        want = '{0};
    drive('0, 1'b1);
    px = bus.cursor_x;
    drive(mk(0, 0, SC_D), 1'b0);
    if (bus.cursor_x !== px) seen.push_back(0);
    px = bus.cursor_x;
    for (int e = 1; e < 45; e++) begin
      drive((e == 33) ? mk(0, 1, SC_D) : 11'd0, 1'b0);
      if (bus.cursor_x !== px) seen.push_back(e);
      px = bus.cursor_x;
    end
    n_cmp++;
    if (seen.size() != want.size()) begin
      n_bad++; $display("FAIL repeat_count: got %0d steps want %0d", seen.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < seen.size(); i++) begin
      n_cmp++;
      if (seen[i] != want[i]) begin
        n_bad++; $display("FAIL repeat_edge_%0d: got +%0d want +%0d", i, seen[i] + 1, want[i] + 1);
      end
    end
    // A new key landing on a tick edge wins; the tick is discarded
    drive('0, 1'b1);
    drive(mk(0, 0, SC_D), 1'b0);
    for (int e = 1; e < 45; e++) begin
      drive((e == 20) ? mk(0, 0, SC_S) : 11'd0, 1'b0);
      n_cmp++;
      if (outs() !== mouts()) begin
        n_bad++; $display("FAIL event_wins_%0d: got %b want %b", e, outs(), mouts());
      end
    end
    drive(mk(0, 1, SC_S), 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    drive('0, 1'b1);
    drive(mk(0, 0, SC_A), 1'b0);
    n_cmp++;
    if (outs() !== {3'd7, 3'd0, 3'b001}) begin
      n_bad++; $display("FAIL hold_a: got %b want %b", outs(), {3'd7, 3'd0, 3'b001});
    end
    for (int i = 0; i < 24; i++) drive('0, 1'b0);
    drive('0, 1'b1);
    drive(mk(0, 1, SC_A), 1'b0);
    n_cmp++;
    if (outs() !== 9'b0) begin
      n_bad++; $display("FAIL reset_mid_hold: got %b want %b", outs(), 9'b0);
    end
    for (int i = 0; i < 25; i++) drive('0, 1'b0);
    n_cmp++;
    if (outs() !== 9'b0) begin
      n_bad++; $display("FAIL reset_mid_hold_quiet: got %b want %b", outs(), 9'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seq [6];
    logic [8:0]  exp [6];
    seq = '{mk(0, 0, SC_D), mk(0, 0, SC_S), mk(0, 0, SC_SPACE),
            mk(0, 0, SC_G), mk(0, 1, SC_S), mk(0, 1, SC_G)};
    exp = '{{3'd1, 3'd0, 3'b001}, {3'd1, 3'd1, 3'b001}, {3'd1, 3'd1, 3'b101},
            {3'd1, 3'd1, 3'b011}, {3'd1, 3'd1, 3'b001}, {3'd1, 3'd1, 3'b000}};
    drive('0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b0);
      n_cmp++;
      if (outs() !== exp[i]) begin
        n_bad++; $display("FAIL back_to_back_%0d: got %b want %b", i, outs(), exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [16];
    logic [10:0] ev;
    logic [7:0]  c;
    bit e, b, r;
    pool = '{SC_W, SC_S, SC_X, SC_A, SC_D, SC_Q, SC_E, SC_Z, SC_C,
             SC_SPACE, SC_G, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, 8'h00};
    drive('0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      ev = '0;
      if ($urandom_range(0, 9) < 2) begin
        c = pool[$urandom_range(0, 15)];
        b = ($urandom_range(0, 9) < 4);
        if (c == SC_UP || c == SC_DOWN || c == SC_LEFT || c == SC_RIGHT)
          e = ($urandom_range(0, 9) != 0);
        else
          e = ($urandom_range(0, 9) == 0);
        if (b && mheld && $urandom_range(0, 1) == 1) begin
          c = mcode;
          e = mext;
        end
        ev = mk(e, b, c);
      end
      drive(ev, r);
      n_cmp++;
      if (outs() !== mouts()) begin
        n_bad++; $display("FAIL random_%0d: ev %h rst %0d got %b want %b", i, ev, r, outs(), mouts());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.key_event = '0;
    test_reset();
    test_make_d();
    test_wrap();
    test_typematic();
    test_pulses();
    test_repeat();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
